// File: rtl/mode_counter.sv
// rtl/mode_counter.sv - up/down counter with saturate or wrap at a programmable terminal value
module mode_counter #(
    parameter int                       COUNTER_WIDTH     = 8,
    parameter logic [COUNTER_WIDTH-1:0] COUNTER_THRESHOLD = {COUNTER_WIDTH{1'b1}},
    parameter int                       COUNTER_MODE      = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     dir,
    input  logic                     clear,
    input  logic                     load,
    input  logic [COUNTER_WIDTH-1:0] load_value,
    output logic [COUNTER_WIDTH-1:0] counter,
    output logic                     terminal,
    output logic                     wrap,
    output logic                     over_run
);

    localparam logic [COUNTER_WIDTH-1:0] ONE = COUNTER_WIDTH'(1);

    logic [COUNTER_WIDTH-1:0] terminal_value;
    logic [COUNTER_WIDTH-1:0] load_clamped;
    logic [COUNTER_WIDTH-1:0] wrap_value;

    // Terminal depends on the direction sampled this cycle; reload value is the opposite end.
    always_comb begin
        terminal_value = dir ? '0 : COUNTER_THRESHOLD;
        wrap_value     = dir ? COUNTER_THRESHOLD : '0;
        load_clamped   = (load_value > COUNTER_THRESHOLD) ? COUNTER_THRESHOLD : load_value;
        terminal       = (counter == terminal_value);
    end

    // Count register with clear > load > enable > hold priority; over_run is sticky until clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter  <= '0;
            wrap     <= 1'b0;
            over_run <= 1'b0;
        end else if (clear) begin
            counter  <= '0;
            wrap     <= 1'b0;
            over_run <= 1'b0;
        end else if (load) begin
            counter  <= load_clamped;
            wrap     <= 1'b0;
        end else if (en) begin
            if (terminal) begin
                over_run <= 1'b1;
                if (COUNTER_MODE == 1) begin
                    counter <= wrap_value;
                    wrap    <= 1'b1;
                end else begin
                    wrap    <= 1'b0;
                end
            end else begin
                counter <= dir ? (counter - ONE) : (counter + ONE);
                wrap    <= 1'b0;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: doc/mode_counter.md
MODE_COUNTER -- requirements
Module: mode_counter

Interface
REQ-001 Parameter COUNTER_WIDTH, default 8: count register width in bits; legal 1..32.
REQ-002 Parameter COUNTER_THRESHOLD, default 2**COUNTER_WIDTH-1: terminal value for up-count and reload value for down-wrap; legal 0..2**COUNTER_WIDTH-1.
REQ-003 Parameter COUNTER_MODE, default 0: 0 = saturate (hold at terminal), 1 = wrap.
REQ-004 clk  input  1  system clock; all state updates on the rising edge.
REQ-005 rst  input  1  system reset; asynchronous, active-low.
REQ-006 en  input  1  count enable; one step per cycle while high.
REQ-007 dir  input  1  direction: 0 = up toward COUNTER_THRESHOLD, 1 = down toward 0.
REQ-008 clear  input  1  synchronous clear of count and over_run.
REQ-009 load  input  1  synchronous load of load_value.
REQ-010 load_value  input  COUNTER_WIDTH  value captured when load is high.
REQ-011 counter  output  COUNTER_WIDTH  current count, registered.
REQ-012 terminal  output  1  high while counter equals the terminal value for the current dir (THRESHOLD up, 0 down); combinational from counter and dir.
REQ-013 wrap  output  1  registered one-cycle pulse, high in the cycle after a wrap step.
REQ-014 over_run  output  1  registered sticky flag; high after any enabled step attempted at terminal.

Function
REQ-015 Per-cycle priority SHALL be clear > load > en > hold.
REQ-016 clear: counter <= 0, over_run <= 0, wrap <= 0.
REQ-017 load: counter <= min(load_value, COUNTER_THRESHOLD); over_run unchanged; wrap <= 0.
REQ-018 en, not at terminal: counter steps +1 (dir=0) or -1 (dir=1); wrap <= 0.
REQ-019 en, at terminal, COUNTER_MODE=0: counter holds; over_run <= 1; wrap <= 0.
REQ-020 en, at terminal, COUNTER_MODE=1: up -> counter <= 0; down -> counter <= COUNTER_THRESHOLD; wrap <= 1; over_run <= 1.
REQ-021 en low with no clear/load: counter and over_run hold; wrap <= 0.
REQ-022 Counter SHALL never exceed COUNTER_THRESHOLD; all arithmetic at COUNTER_WIDTH bits with no carry-out visible.
REQ-023 dir may change any cycle; the terminal test SHALL use dir sampled in that same cycle.
REQ-024 COUNTER_THRESHOLD=0: terminal always high; every enabled cycle sets over_run; mode 1 pulses wrap every enabled cycle while counter stays 0.
REQ-025 over_run SHALL clear only via clear or reset; load does not clear it.
REQ-026 Latency: each input affects counter/wrap/over_run at the next rising edge; terminal follows counter combinationally.

Reset
REQ-027 rst low SHALL immediately force counter=0, wrap=0, over_run=0, independent of clk.
REQ-028 Reset asserted mid-count SHALL discard the count; the first enabled edge after rst rises SHALL produce counter=1 (dir=0).
REQ-029 No output SHALL be X after reset regardless of input state.

Verification
REQ-030 WIDTH=4, THRESH=9, MODE=0, dir=0, en=1 for 12 cycles -> counter 1..9 then holds 9; terminal at 9; over_run rises on first step attempted at 9; wrap stays 0.
REQ-031 WIDTH=4, THRESH=9, MODE=1, dir=1 from 0 -> counter 9, wrap pulse one cycle, over_run=1; next cycles 8, 7.
REQ-032 load=1, load_value=15, THRESH=9 -> counter=9; same cycle clear=1 and load=1 -> counter=0, over_run=0.
REQ-033 Counter=5, toggle dir every cycle with en=1 -> 6,5,6,5; no wrap, no over_run.
REQ-034 rst driven low between clock edges at counter=7 -> counter=0 before next edge; release, en=1 -> counter=1 after one edge.
REQ-035 THRESH=0, MODE=1, en=1 for 3 cycles -> counter stays 0, wrap high each cycle, over_run=1.
